// File: rtl/logs_motion_if.sv
// Renderer-facing bundle of logs_motion: per-lane log x positions, log lengths,
// lane directions, per-lane step pulses and the running flag.
interface logs_motion_if;
    logic [9:0] lane0_log0_x, lane1_log0_x, lane2_log0_x, lane3_log0_x, lane4_log0_x, lane5_log0_x;
    logic [9:0] lane0_log1_x, lane1_log1_x, lane2_log1_x, lane3_log1_x, lane4_log1_x, lane5_log1_x;
    logic [9:0] lane0_loglength, lane1_loglength, lane2_loglength;
    logic [9:0] lane3_loglength, lane4_loglength, lane5_loglength;
    logic [5:0] lane_dir;
    logic [5:0] lane_moved;
    logic       running;

    modport master (
        output lane0_log0_x, lane1_log0_x, lane2_log0_x, lane3_log0_x, lane4_log0_x, lane5_log0_x,
        output lane0_log1_x, lane1_log1_x, lane2_log1_x, lane3_log1_x, lane4_log1_x, lane5_log1_x,
        output lane0_loglength, lane1_loglength, lane2_loglength,
        output lane3_loglength, lane4_loglength, lane5_loglength,
        output lane_dir, lane_moved, running
    );

    modport slave (
        input lane0_log0_x, lane1_log0_x, lane2_log0_x, lane3_log0_x, lane4_log0_x, lane5_log0_x,
        input lane0_log1_x, lane1_log1_x, lane2_log1_x, lane3_log1_x, lane4_log1_x, lane5_log1_x,
        input lane0_loglength, lane1_loglength, lane2_loglength,
        input lane3_loglength, lane4_loglength, lane5_loglength,
        input lane_dir, lane_moved, running
    );
endinterface

// File: rtl/logs_motion.sv
// River-log x-position engine: six lanes, two logs each, frame-rate dividers and wrap.
// Optional LOGS_MOTION_PAUSE_EN adds a pause input that freezes motion while in RUN.
module logs_motion #(
    parameter int BLOCKSIZE      = 32,
    parameter int X_OFFSET_LEFT  = 96,
    parameter int X_OFFSET_RIGHT = 544,
    parameter int LANE0_PERIOD   = 4,
    parameter int LANE1_PERIOD   = 3,
    parameter int LANE2_PERIOD   = 2,
    parameter int LANE3_PERIOD   = 3,
    parameter int LANE4_PERIOD   = 4,
    parameter int LANE5_PERIOD   = 2,
    parameter int LANE0_LEN      = 96,
    parameter int LANE1_LEN      = 64,
    parameter int LANE2_LEN      = 96,
    parameter int LANE3_LEN      = 64,
    parameter int LANE4_LEN      = 96,
    parameter int LANE5_LEN      = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          frame_tick,
    input  logic          start,
    input  logic          stop,
    input  logic [1:0]    level,
`ifdef LOGS_MOTION_PAUSE_EN
    input  logic          pause,
`endif
    logs_motion_if.master rif
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [9:0] XL = 10'(X_OFFSET_LEFT);
    localparam logic [9:0] XR = 10'(X_OFFSET_RIGHT);

    localparam logic [5:0][3:0] PERIOD = {4'(LANE5_PERIOD), 4'(LANE4_PERIOD), 4'(LANE3_PERIOD),
                                          4'(LANE2_PERIOD), 4'(LANE1_PERIOD), 4'(LANE0_PERIOD)};
    localparam logic [5:0][9:0] LEN    = {10'(LANE5_LEN), 10'(LANE4_LEN), 10'(LANE3_LEN),
                                          10'(LANE2_LEN), 10'(LANE1_LEN), 10'(LANE0_LEN)};
    // Even lanes move right, odd lanes move left.
    localparam logic [5:0]      DIR    = 6'b010101;

    function automatic logic [3:0] eff_period(input logic [3:0] p, input logic [1:0] lvl);
        logic [3:0] s;
        s = p >> lvl;
        return (s == 4'd0) ? 4'd1 : s;
    endfunction

    function automatic logic [9:0] init_x(input int lane, input int base);
        return 10'(X_OFFSET_LEFT + base + BLOCKSIZE * lane);
    endfunction

    function automatic logic [9:0] move_x(input logic [9:0] x, input logic [9:0] len,
                                          input logic right);
        logic [9:0] nx;
        logic [9:0] tail;
        if (right) begin
            nx = x + 10'd1;
            return (nx >= XR) ? (XL - len) : nx;
        end
        nx   = x - 10'd1;
        tail = nx + len;
        return (tail <= XL) ? XR : nx;
    endfunction

    logic [0:0] state_q, state_d;
    logic [3:0] cnt_q [6];
    logic [3:0] cnt_d [6];
    logic [9:0] x0_q  [6];
    logic [9:0] x0_d  [6];
    logic [9:0] x1_q  [6];
    logic [9:0] x1_d  [6];
    logic [5:0] moved_q, moved_d;
    logic       advance;

`ifdef LOGS_MOTION_PAUSE_EN
    assign advance = frame_tick & ~pause;
`else
    assign advance = frame_tick;
`endif

    always_comb begin
        state_d = state_q;
        moved_d = 6'd0;
        for (int n = 0; n < 6; n++) begin
            cnt_d[n] = cnt_q[n];
            x0_d[n]  = x0_q[n];
            x1_d[n]  = x1_q[n];
        end
        if (stop) begin
            state_d = ST_IDLE;
        end else if (start) begin
            state_d = ST_RUN;
            for (int n = 0; n < 6; n++) begin
                cnt_d[n] = eff_period(PERIOD[n], level);
                x0_d[n]  = init_x(n, 0);
                x1_d[n]  = init_x(n, 7 * BLOCKSIZE);
            end
        end else if (state_q == ST_RUN && advance) begin
            // level only takes effect here, at reload; in-flight counts run out untouched.
            for (int n = 0; n < 6; n++) begin
                if (cnt_q[n] <= 4'd1) begin
                    cnt_d[n]   = eff_period(PERIOD[n], level);
                    moved_d[n] = 1'b1;
                    x0_d[n]    = move_x(x0_q[n], LEN[n], DIR[n]);
                    x1_d[n]    = move_x(x1_q[n], LEN[n], DIR[n]);
                end else begin
                    cnt_d[n] = cnt_q[n] - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            moved_q <= 6'd0;
            for (int n = 0; n < 6; n++) begin
                cnt_q[n] <= 4'd0;
                x0_q[n]  <= init_x(n, 0);
                x1_q[n]  <= init_x(n, 7 * BLOCKSIZE);
            end
        end else begin
            state_q <= state_d;
            moved_q <= moved_d;
            for (int n = 0; n < 6; n++) begin
                cnt_q[n] <= cnt_d[n];
                x0_q[n]  <= x0_d[n];
                x1_q[n]  <= x1_d[n];
            end
        end
    end

    assign rif.lane0_log0_x = x0_q[0];
    assign rif.lane1_log0_x = x0_q[1];
    assign rif.lane2_log0_x = x0_q[2];
    assign rif.lane3_log0_x = x0_q[3];
    assign rif.lane4_log0_x = x0_q[4];
    assign rif.lane5_log0_x = x0_q[5];
    assign rif.lane0_log1_x = x1_q[0];
    assign rif.lane1_log1_x = x1_q[1];
    assign rif.lane2_log1_x = x1_q[2];
    assign rif.lane3_log1_x = x1_q[3];
    assign rif.lane4_log1_x = x1_q[4];
    assign rif.lane5_log1_x = x1_q[5];

    assign rif.lane0_loglength = LEN[0];
    assign rif.lane1_loglength = LEN[1];
    assign rif.lane2_loglength = LEN[2];
    assign rif.lane3_loglength = LEN[3];
    assign rif.lane4_loglength = LEN[4];
    assign rif.lane5_loglength = LEN[5];

    assign rif.lane_dir   = DIR;
    assign rif.lane_moved = moved_q;
    assign rif.running    = (state_q == ST_RUN);

endmodule

// File: tb/tb_logs_motion.sv
// Scoreboard bench for logs_motion: a behavioural model queues the expected lane
// state for every driven cycle, which is compared once the DUT registers its outputs.
module tb_logs_motion;

    typedef struct packed {
        logic            run;
        logic [5:0]      moved;
        logic [5:0][9:0] x0;
        logic [5:0][9:0] x1;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [1:0] level = 2'd0;

    logs_motion_if rif ();

    logs_motion dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .start      (start),
        .stop       (stop),
        .level      (level),
        .rif        (rif)
    );

    always #5 clk = ~clk;

    logic [5:0][9:0] dx0, dx1, dlen;
    assign dx0  = {rif.lane5_log0_x, rif.lane4_log0_x, rif.lane3_log0_x,
                   rif.lane2_log0_x, rif.lane1_log0_x, rif.lane0_log0_x};
    assign dx1  = {rif.lane5_log1_x, rif.lane4_log1_x, rif.lane3_log1_x,
                   rif.lane2_log1_x, rif.lane1_log1_x, rif.lane0_log1_x};
    assign dlen = {rif.lane5_loglength, rif.lane4_loglength, rif.lane3_loglength,
                   rif.lane2_loglength, rif.lane1_loglength, rif.lane0_loglength};

    int vectors = 0;
    int miscompares = 0;
    exp_t sb_q[$];

    // Behavioural model state
    int m_period [6] = '{4, 3, 2, 3, 4, 2};
    int m_len    [6] = '{96, 64, 96, 64, 96, 64};
    int m_cnt [6];
    int m_x0  [6];
    int m_x1  [6];
    bit m_run;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic int m_eff(input int p, input int lvl);
        int s;
        s = p >> lvl;
        return (s == 0) ? 1 : s;
    endfunction

    function automatic int m_move(input int x, input int len, input bit right);
        int nx;
        if (right) begin
            nx = x + 1;
            return (nx >= 544) ? (96 - len) : nx;
        end
        nx = x - 1;
        return (nx + len <= 96) ? 544 : nx;
    endfunction

    task automatic m_reset();
        m_run = 1'b0;
        for (int n = 0; n < 6; n++) begin
            m_cnt[n] = 0;
            m_x0[n]  = 96 + 32 * n;
            m_x1[n]  = 320 + 32 * n;
        end
    endtask

    task automatic push_exp(input logic [5:0] moved);
        exp_t e;
        e.run   = m_run;
        e.moved = moved;
        for (int n = 0; n < 6; n++) begin
            e.x0[n] = 10'(m_x0[n]);
            e.x1[n] = 10'(m_x1[n]);
        end
        sb_q.push_back(e);
    endtask

    task automatic pop_compare();
        exp_t e;
        if (sb_q.size() == 0) begin
            check_val("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sb_q.pop_front();
        check_val("running", {31'd0, rif.running}, {31'd0, e.run});
        check_val("lane_moved", {26'd0, rif.lane_moved}, {26'd0, e.moved});
        for (int n = 0; n < 6; n++) begin
            check_val($sformatf("lane%0d_log0_x", n), {22'd0, dx0[n]}, {22'd0, e.x0[n]});
            check_val($sformatf("lane%0d_log1_x", n), {22'd0, dx1[n]}, {22'd0, e.x1[n]});
        end
    endtask

    // One cycle with the given control pulses; the model predicts the registered result.
    task automatic drive(input bit st, input bit sp, input bit ft);
        logic [5:0] mv;
        @(negedge clk);
        start = st; stop = sp; frame_tick = ft;
        mv = 6'd0;
        if (sp) begin
            m_run = 1'b0;
        end else if (st) begin
            m_run = 1'b1;
            for (int n = 0; n < 6; n++) begin
                m_cnt[n] = m_eff(m_period[n], level);
                m_x0[n]  = 96 + 32 * n;
                m_x1[n]  = 320 + 32 * n;
            end
        end else if (m_run && ft) begin
            for (int n = 0; n < 6; n++) begin
                if (m_cnt[n] == 1) begin
                    m_cnt[n] = m_eff(m_period[n], level);
                    mv[n]    = 1'b1;
                    m_x0[n]  = m_move(m_x0[n], m_len[n], (n % 2) == 0);
                    m_x1[n]  = m_move(m_x1[n], m_len[n], (n % 2) == 0);
                end else begin
                    m_cnt[n] = m_cnt[n] - 1;
                end
            end
        end
        push_exp(mv);
        @(posedge clk);
        #1;
        start = 1'b0; stop = 1'b0; frame_tick = 1'b0;
        pop_compare();
    endtask

    task automatic tick();
        drive(1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        check_val("moved_clear", {26'd0, rif.lane_moved}, 32'd0);
    endtask

    initial begin
        int moved0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_running", {31'd0, rif.running}, 32'd0);
        check_val("rst_moved", {26'd0, rif.lane_moved}, 32'd0);
        check_val("rst_l0_x0", {22'd0, dx0[0]}, 32'd96);
        check_val("rst_l0_x1", {22'd0, dx1[0]}, 32'd320);
        check_val("lane_dir", {26'd0, rif.lane_dir}, 32'h15);
        for (int n = 0; n < 6; n++)
            check_val($sformatf("loglength%0d", n), {22'd0, dlen[n]}, (n % 2) ? 32'd64 : 32'd96);
        @(negedge clk);
        reset = 1'b0;

        // frame_tick while IDLE does nothing
        tick();
        tick();

        // Level 0: lane0 steps on the 4th tick, lane2 every 2nd
        level = 2'd0;
        drive(1'b1, 1'b0, 1'b0);
        moved0 = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i < 3) check_val("l0_before4", {22'd0, dx0[0]}, 32'd96);
        end
        check_val("l0_x0_after4", {22'd0, dx0[0]}, 32'd97);
        check_val("l0_x1_after4", {22'd0, dx1[0]}, 32'd321);
        check_val("l2_x0_after4", {22'd0, dx0[2]}, 32'd162);

        // lane_moved[0] pulses exactly once in 4 ticks
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 1'b1);
            if (rif.lane_moved[0]) moved0++;
        end
        check_val("l0_pulse_count", moved0, 32'd1);

        // Level change mid-count does not truncate the in-flight count
        drive(1'b1, 1'b0, 1'b0);
        tick();
        level = 2'd2;
        for (int i = 0; i < 6; i++) tick();

        // Level 2: every lane steps on every tick
        drive(1'b1, 1'b0, 1'b0);
        tick();
        check_val("all_moved", {26'd0, rif.lane_moved}, 32'd0);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        check_val("all_moved_pulse", {26'd0, rif.lane_moved}, 32'h3F);
        @(posedge clk);
        #1;

        // Wrap runs from fresh start: lane1 left wrap at 96 steps, lane0 right wrap at 448
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 448; i++) begin
            tick();
            if (i == 94)  check_val("l1_at34", {22'd0, dx0[1]}, 32'd34);
            if (i == 95)  check_val("l1_34to33", {22'd0, dx0[1]}, 32'd33);
            if (i == 96)  check_val("l1_wrap544", {22'd0, dx0[1]}, 32'd544);
            if (i == 447) check_val("l0_at543", {22'd0, dx0[0]}, 32'd543);
            if (i == 448) check_val("l0_wrap0", {22'd0, dx0[0]}, 32'd0);
        end

        // stop freezes positions; 10 ticks are ignored
        drive(1'b0, 1'b1, 1'b0);
        check_val("stop_running", {31'd0, rif.running}, 32'd0);
        for (int i = 0; i < 10; i++) tick();
        check_val("stop_l0_x0", {22'd0, dx0[0]}, 32'd0);

        // start and stop together: stop wins
        drive(1'b1, 1'b1, 1'b0);
        tick();

        drive(1'b1, 1'b0, 1'b0);
        check_val("restart_x0", {22'd0, dx0[0]}, 32'd96);
        check_val("restart_x1", {22'd0, dx1[0]}, 32'd320);
        for (int i = 0; i < 5; i++) tick();

        // Asynchronous reset between clock edges
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_val("arst_running", {31'd0, rif.running}, 32'd0);
        check_val("arst_l0_x0", {22'd0, dx0[0]}, 32'd96);
        check_val("arst_l5_x1", {22'd0, dx1[5]}, 32'd480);
        check_val("arst_moved", {26'd0, rif.lane_moved}, 32'd0);
        m_reset();
        @(negedge clk);
        reset = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/logs_motion.md
Name: logs_motion

Overview:
- Upstream stage of the river-log renderer: owns the x-position registers for the two logs in each of the six river lanes.
- Advances each lane at its own frame-rate-derived speed and wraps logs across the 96..543 playfield.
- Drives the renderer's laneN_logK_x / laneN_loglength inputs.
- Emits per-lane step pulses so the frog-ride logic can carry a frog standing on a log.

Parameters:
- BLOCKSIZE, 32, tile size in pixels.
- X_OFFSET_LEFT, 96, first visible playfield column.
- X_OFFSET_RIGHT, 544, first column past the playfield.
- LANE0_PERIOD..LANE5_PERIOD, 4/3/2/3/4/2, frames per 1-pixel step at level 0 (4-bit each).
- LANE0_LEN..LANE5_LEN, 96/64/96/64/96/64, log length in pixels; each is a multiple of BLOCKSIZE and ≤ X_OFFSET_LEFT.

Ports:
- clk  in  1  system/pixel clock.
- reset  in  1  asynchronous, active-high.
- frame_tick  in  1  one-clk pulse per frame (vblank start).
- start  in  1  pulse; loads initial positions and enters RUN.
- stop  in  1  pulse; returns to IDLE with positions frozen.
- level  in  2  speed level; effective period = max(1, LANEn_PERIOD >> level).
- laneN_log0_x, laneN_log1_x (N=0..5)  out  10 each  log left-edge x.
- laneN_loglength (N=0..5)  out  10 each  constant, equal to LANEn_LEN.
- lane_dir  out  6  constant per lane: 1 = moving right (even lanes), 0 = moving left (odd lanes).
- lane_moved  out  6  one-clk pulse; lane n stepped this frame.
- running  out  1  high in RUN.

Behaviour:
- Reset: state IDLE; running=0; lane_moved=0; per-lane divider counters=0.
- Reset initial positions: logK_x loaded with the initial positions below.
  - laneN_log0_x = X_OFFSET_LEFT + 32·N.
  - laneN_log1_x = X_OFFSET_LEFT + 224 + 32·N.
- FSM: IDLE, RUN.
  - IDLE→RUN on start: reload initial positions; counters load their effective periods.
  - RUN→IDLE on stop: positions hold and counters hold.
  - start in RUN: re-initialises positions and counters; stays in RUN.
  - start and stop in the same cycle: stop wins.
- In RUN, per lane, on each frame_tick:
  - If the counter is 1, reload it with the effective period and step both logs 1 pixel.
  - Otherwise decrement the counter.
- level is sampled at counter reload only; a level change never truncates an in-flight count.
- Latency: new x values and the lane_moved[n] pulse are registered and appear together 1 clk after frame_tick.
- Right-moving wrap: if x+1 ≥ X_OFFSET_RIGHT then x ← X_OFFSET_LEFT − len, else x+1.
- Left-moving wrap: if (x−1)+len ≤ X_OFFSET_LEFT then x ← X_OFFSET_RIGHT, else x−1.
- All arithmetic is 10-bit unsigned. No underflow is possible, given len ≤ X_OFFSET_LEFT and x ≥ X_OFFSET_LEFT − len.
- frame_tick in IDLE is ignored; lane_moved stays 0.
- Asynchronous reset mid-RUN: immediately forces IDLE and initial positions.

Optional Feature:
- Macro: LOGS_MOTION_PAUSE_EN.
- Defined: adds input port pause (1 bit). While pause=1 in RUN, frame_tick is ignored, counters and positions hold, and lane_moved=0. running stays 1. On release, motion resumes with the remaining counts.
- Undefined: the port is absent; behaviour is as above.

Test Plan:
- Reset then start, level=0, 4 frame_ticks:
  - lane0_log0_x 96→97 and lane0_log1_x 320→321, 1 clk after the 4th tick.
  - lane_moved[0] pulses once.
  - lane2 has stepped twice: 160→162.
- level=2, start, 1 frame_tick: every lane steps (effective period 1); lane_moved=6'b111111.
- Right wrap: lane0_log0_x reaches 543, next lane0 step → lane0_log0_x=0 (96−96).
- Left wrap: lane1 log (len 64) at x=33, next lane1 step → x=544; at x=34 the step → 33.
- stop during RUN, 10 frame_ticks: positions unchanged and lane_moved=0; start then reloads 96/320.
- Reset asserted mid-RUN, asynchronously between clock edges: running=0 and positions equal the initial values before the next clk edge.
